// File: rtl/apb3_master_pkg.sv
// Shared types and default constants for the APB3 command-to-bus master.
// Defining APB3_MASTER_TIMEOUT_EN enables the ACCESS-phase timeout in apb3_master.
package apb3_master_pkg;

  localparam int unsigned APB_ADDR_WIDTH_DEF = 32;
  localparam int unsigned APB_DATA_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb3_master.sv
// APB3 master: accepts one command, runs a SETUP/ACCESS transfer, holds the response until taken.
// Optional macro APB3_MASTER_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait cycles.
module apb3_master
  import apb3_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
  parameter int unsigned APB_DATA_WIDTH = APB_DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      i_apb_pclk,
  input  logic                      i_apb_presetn,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
  input  logic                      i_req_write,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic                      o_rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb3_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`endif

  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
    if (!i_apb_presetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB3_MASTER_TIMEOUT_EN
      cnt_q   <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB3_MASTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB3_MASTER_TIMEOUT_EN
    cnt_d   = cnt_q;
    tout_d  = tout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          write_d = i_req_write;
          state_d = SETUP;
        end
      end
      SETUP: begin
`ifdef APB3_MASTER_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        if (i_apb_pready) begin
          // Write responses carry zero data regardless of what the slave drives.
          rdata_d = write_q ? '0 : i_apb_prdata;
          err_d   = i_apb_pslverr;
`ifdef APB3_MASTER_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef APB3_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tout_d  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_req_ready   = (state_q == IDLE);
  assign o_apb_psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign o_apb_penable = (state_q == ACCESS);
  assign o_rsp_valid   = (state_q == RESP);
  assign o_apb_paddr   = addr_q;
  assign o_apb_pwdata  = wdata_q;
  assign o_apb_pwrite  = write_q;
  assign o_rsp_rdata   = rdata_q;
  assign o_rsp_err     = err_q;
`ifdef APB3_MASTER_TIMEOUT_EN
  assign o_rsp_timeout = tout_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

endmodule
